raised_receiver: RTL and testbench
==================================

Name: raised_receiver

Overview:
- Downstream stage of the raised-cosine pulse transmitter. Consumes its 16-bit signed sample stream at 10 samples per bit-pair segment and 20 segments per frame.
- Recovers the 21-bit frame word by threshold decisions at segment boundaries.
- Presents the word to the frame consumer with a valid/taken handshake, plus overrun and timeout flags.

Parameters:
SPS, 10, samples per segment
NSEG, 20, segments per frame (frame = SPS*NSEG samples, NSEG+1 bits)
THRESH, 13000, signed decision threshold (17-bit signed compare)
TIMEOUT, 1024, idle cycles mid-frame before abort

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
indata  in  16  signed sample from transmitter outdata
inready  in  1  one-cycle sample strobe (transmitter writeready)
waitwrite  out  1  receiver can accept a sample (drives transmitter waitwrite)
outdata  out  21  recovered frame word
outvalid  out  1  outdata valid, held until taken
outtaken  in  1  consumer acknowledges outdata
overrun  out  1  sticky: frame completed while previous word untaken
timeout_err  out  1  sticky: frame aborted by timeout
busy  out  1  high in RECV and DONE

Behaviour:
- One clock domain. Reset is synchronous and active-low, sampled on posedge clk.
- Reset values: outdata=0, outvalid=0, overrun=0, timeout_err=0, busy=0, waitwrite=0; state=IDLE, seg=0, phase=0, shift register=0, timer=0. A reset mid-frame discards all partial data.
- States: IDLE, RECV, DONE.
- IDLE:
  - waitwrite=1.
  - On inready: clear timeout_err, treat the sample as seg 0 / phase 0, go to RECV.
- RECV:
  - waitwrite=1.
  - On each inready: phase++. Phase wraps SPS-1→0, incrementing seg.
  - Decision at phase 0 of every segment: bit = (indata > THRESH), signed compare. Shift the bit left into the 21-bit register (first bit ends at outdata[20]).
  - On seg=NSEG-1 and phase=SPS-1: shift in a final decision from that sample (lands in outdata[0]), go to DONE.
- Timer:
  - Cleared on every inready; otherwise increments in RECV.
  - At TIMEOUT-1 without a sample: timeout_err=1, discard partial word, go to IDLE. outvalid/outdata are untouched.
- DONE (exactly one cycle):
  - waitwrite=0. Any inready this cycle is ignored.
  - outdata <= shift register, outvalid <= 1.
  - If outvalid was already 1 and outtaken is low this cycle, set overrun=1; the new word overwrites.
  - Go to IDLE.
- outvalid clears the cycle after outtaken is seen high. If outtaken coincides with the DONE load, the load wins and outvalid stays 1 (no overrun).
- overrun clears only on reset.
- Latency: outvalid is visible 2 clocks after the inready carrying sample SPS*NSEG.
- Samples with inready low are never consumed. Gaps between strobes of any length below TIMEOUT are legal.

Optional Feature:
RX_SUM_EN
- Defined: the decision for the bits landing at outdata[19:1] uses the 17-bit signed sum of the previous segment's phase SPS-1 sample and the current phase-0 sample, compared against 2*THRESH. Requires a registered last-sample.
- The first bit (outdata[20]) and the final bit (outdata[0]) still use a single-sample compare against THRESH.
- Undefined: single-sample decisions only, and no last-sample register is built.

Test Plan:
- Transmitter-generated samples for 21'h155555 with waitwrite looped back -> outdata=21'h155555, outvalid=1 two clocks after sample 200; overrun=0 and timeout_err=0.
- 200 zero samples, then 200 samples for 21'h1FFFFF -> outdata 21'h000000, then outtaken pulse, then 21'h1FFFFF.
- Threshold boundary: phase-0 samples of exactly 13000 decode as 0; 13001 decode as 1; -1665 decodes as 0.
- Stop after 57 samples and idle 1024 cycles -> timeout_err=1, outvalid unchanged. Next full frame 21'h0ABCDE decodes correctly and timeout_err clears on its first sample.
- Two frames with no outtaken -> overrun=1, outdata holds the second word. Strobe inready during DONE -> sample ignored, next frame unaffected.
- Assert reset (low) after 100 samples -> all outputs at reset values. After release, a full frame 21'h1C0F03 decodes correctly.

Source files
------------

// File: rtl/raised_receiver.sv
// Raised-cosine frame receiver: slices the transmitter's sample stream into 21-bit words.
// Optional macro RX_SUM_EN: inner bit decisions use the sum of two adjacent samples.
module raised_receiver #(
  parameter int SPS     = 10,
  parameter int NSEG    = 20,
  parameter int THRESH  = 13000,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       indata,
  input  logic              inready,
  output logic              waitwrite,
  output logic [NSEG:0]     outdata,
  output logic              outvalid,
  input  logic              outtaken,
  output logic              overrun,
  output logic              timeout_err,
  output logic              busy
);

  localparam int PW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int SW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic signed [16:0] THRESH1 = 17'(THRESH);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t        state, nextstate;
  logic [PW-1:0] phase;
  logic [SW-1:0] seg;
  logic [TW-1:0] timer;
  logic [NSEG:0] shreg;

  logic lastphase, lastseg, expire, single, decision;

  assign lastphase = (phase == PW'(SPS - 1));
  assign lastseg   = (seg == SW'(NSEG - 1));
  assign expire    = (state == RECV) && !inready && (timer == TW'(TIMEOUT - 1));
  assign single    = $signed({indata[15], indata}) > THRESH1;
  assign busy      = (state == RECV) || (state == DONE);

`ifdef RX_SUM_EN
  localparam logic signed [16:0] THRESH2 = 17'(2 * THRESH);
  logic [15:0]        lastsample;
  logic signed [16:0] pairsum;

  assign pairsum = $signed({indata[15], indata}) + $signed({lastsample[15], lastsample});

  // Inner segment boundaries (phase 0 while receiving) use the two-sample sum.
  assign decision = (state == RECV && phase == '0) ? (pairsum > THRESH2) : single;

  always_ff @(posedge clk) begin
    if (!reset)
      lastsample <= '0;
    else if (inready && state != DONE)
      lastsample <= indata;
  end
`else
  assign decision = single;
`endif

  always_ff @(posedge clk) begin
    if (!reset)
      state <= IDLE;
    else
      state <= nextstate;
  end

  always_comb begin
    nextstate = state;
    case (state)
      IDLE: if (inready) nextstate = RECV;
      RECV: begin
        if (inready && lastphase && lastseg)
          nextstate = DONE;
        else if (expire)
          nextstate = IDLE;
      end
      DONE:    nextstate = IDLE;
      default: nextstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase       <= '0;
      seg         <= '0;
      timer       <= '0;
      shreg       <= '0;
      outdata     <= '0;
      outvalid    <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      waitwrite   <= 1'b0;
    end else begin
      waitwrite <= (nextstate != DONE);
      // The DONE load takes priority over a same-cycle acknowledge.
      if (state == DONE)
        outvalid <= 1'b1;
      else if (outtaken)
        outvalid <= 1'b0;

      case (state)
        IDLE: begin
          timer <= '0;
          if (inready) begin
            timeout_err <= 1'b0;
            shreg       <= {{NSEG{1'b0}}, single};
            seg         <= '0;
            phase       <= PW'(1);
          end
        end
        RECV: begin
          if (inready) begin
            timer <= '0;
            if (phase == '0 || (lastphase && lastseg))
              shreg <= {shreg[NSEG-1:0], decision};
            if (lastphase) begin
              phase <= '0;
              seg   <= lastseg ? '0 : seg + SW'(1);
            end else begin
              phase <= phase + PW'(1);
            end
          end else if (expire) begin
            timeout_err <= 1'b1;
            shreg       <= '0;
            seg         <= '0;
            phase       <= '0;
            timer       <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE: begin
          outdata <= shreg;
          if (outvalid && !outtaken)
            overrun <= 1'b1;
          timer <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_raised_receiver.sv
// Directed self-checking bench for raised_receiver (default build, RX_SUM_EN undefined).
// Frames are synthesised as ideal decision samples with opposite-polarity filler.
module tb_raised_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] indata = '0;
  logic        inready = 1'b0;
  logic        waitwrite;
  logic [20:0] outdata;
  logic        outvalid;
  logic        outtaken = 1'b0;
  logic        overrun;
  logic        timeout_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  raised_receiver dut (
    .clk(clk), .reset(reset), .indata(indata), .inready(inready),
    .waitwrite(waitwrite), .outdata(outdata), .outvalid(outvalid),
    .outtaken(outtaken), .overrun(overrun), .timeout_err(timeout_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Caller sits 1ns after a rising edge; returns 1ns after the capturing edge.
  task automatic applyStimulus(input logic [15:0] s);
    indata  = s;
    inready = 1'b1;
    @(posedge clk); #1;
    inready = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Decision samples carry the bit; every other sample carries the inverse.
  function automatic logic [15:0] frameSample(input logic [20:0] w, input int k);
    int s;
    logic b;
    s = k / 10;
    if (k == 199) return w[0] ? 16'sd20000 : -16'sd20000;
    b = w[20 - s];
    if (k % 10 == 0) return b ? 16'sd20000 : -16'sd20000;
    return b ? -16'sd20000 : 16'sd20000;
  endfunction

  // Even segments sit exactly on the threshold, odd ones one above it.
  function automatic logic [15:0] thresholdSample(input int k);
    if (k == 199) return -16'sd1665;
    if (k % 10 != 0) return 16'sd0;
    if (k == 40) return -16'sd1665;
    return ((k / 10) % 2 == 1) ? 16'sd13001 : 16'sd13000;
  endfunction

  task automatic sendRange(input logic [20:0] w, input int first, input int last);
    for (int k = first; k <= last; k++) applyStimulus(frameSample(w, k));
  endtask

  task automatic takeWord(input string tag);
    outtaken = 1'b1;
    @(posedge clk); #1;
    outtaken = 1'b0;
    checkOutput(tag, {31'b0, outvalid}, 32'd0);
  endtask

  task automatic checkWord(input string tag, input logic [20:0] w);
    idleCycles(1);
    checkOutput({tag, "_valid"}, {31'b0, outvalid}, 32'd1);
    checkOutput({tag, "_data"}, {11'b0, outdata}, {11'b0, w});
    checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    // Reset state
    idleCycles(2);
    checkOutput("rst_outdata", {11'b0, outdata}, 32'd0);
    checkOutput("rst_outvalid", {31'b0, outvalid}, 32'd0);
    checkOutput("rst_overrun", {31'b0, overrun}, 32'd0);
    checkOutput("rst_timeout", {31'b0, timeout_err}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_waitwrite", {31'b0, waitwrite}, 32'd0);
    reset = 1'b1;
    idleCycles(1);
    checkOutput("idle_waitwrite", {31'b0, waitwrite}, 32'd1);

    // Alternating word plus latency: not yet valid one clock after the last sample
    sendRange(21'h155555, 0, 199);
    checkOutput("lat_valid_early", {31'b0, outvalid}, 32'd0);
    checkOutput("done_waitwrite", {31'b0, waitwrite}, 32'd0);
    checkOutput("done_busy", {31'b0, busy}, 32'd1);
    checkWord("w155555", 21'h155555);
    checkOutput("w155555_overrun", {31'b0, overrun}, 32'd0);
    checkOutput("w155555_timeout", {31'b0, timeout_err}, 32'd0);
    takeWord("take1");

    // All-zero samples, then all ones
    for (int k = 0; k < 200; k++) applyStimulus(16'h0000);
    checkWord("wzero", 21'h000000);
    takeWord("take2");
    sendRange(21'h1FFFFF, 0, 199);
    checkWord("w1fffff", 21'h1FFFFF);
    checkOutput("w1fffff_overrun", {31'b0, overrun}, 32'd0);
    takeWord("take3");

    // Threshold boundary: 13000 and -1665 are 0, 13001 is 1
    for (int k = 0; k < 200; k++) applyStimulus(thresholdSample(k));
    checkWord("thresh", 21'h0AAAAA);

    // Timeout after 57 samples; the held word stays untouched
    sendRange(21'h0ABCDE, 0, 56);
    idleCycles(1023);
    checkOutput("to_before", {31'b0, timeout_err}, 32'd0);
    checkOutput("to_busy_before", {31'b0, busy}, 32'd1);
    idleCycles(1);
    checkOutput("to_flag", {31'b0, timeout_err}, 32'd1);
    checkOutput("to_busy_after", {31'b0, busy}, 32'd0);
    checkOutput("to_valid_kept", {31'b0, outvalid}, 32'd1);
    checkOutput("to_data_kept", {11'b0, outdata}, 32'h0AAAAA);
    takeWord("take4");
    sendRange(21'h0ABCDE, 0, 0);
    checkOutput("to_cleared", {31'b0, timeout_err}, 32'd0);
    sendRange(21'h0ABCDE, 1, 199);
    checkWord("w0abcde", 21'h0ABCDE);
    checkOutput("w0abcde_overrun", {31'b0, overrun}, 32'd0);

    // Second untaken frame sets overrun; a strobe during DONE is ignored
    sendRange(21'h012345, 0, 199);
    indata  = 16'sd20000;
    inready = 1'b1;
    @(posedge clk); #1;
    inready = 1'b0;
    checkOutput("ovr_flag", {31'b0, overrun}, 32'd1);
    checkOutput("ovr_data", {11'b0, outdata}, 32'h012345);
    checkOutput("ovr_busy", {31'b0, busy}, 32'd0);
    takeWord("take5");
    sendRange(21'h01A2B3, 0, 199);
    checkWord("w01a2b3", 21'h01A2B3);
    checkOutput("ovr_sticky", {31'b0, overrun}, 32'd1);

    // Reset mid-frame discards everything
    sendRange(21'h1F0F0F, 0, 99);
    reset = 1'b0;
    idleCycles(1);
    checkOutput("mid_outdata", {11'b0, outdata}, 32'd0);
    checkOutput("mid_outvalid", {31'b0, outvalid}, 32'd0);
    checkOutput("mid_overrun", {31'b0, overrun}, 32'd0);
    checkOutput("mid_timeout", {31'b0, timeout_err}, 32'd0);
    checkOutput("mid_busy", {31'b0, busy}, 32'd0);
    checkOutput("mid_waitwrite", {31'b0, waitwrite}, 32'd0);
    reset = 1'b1;
    idleCycles(1);
    sendRange(21'h1C0F03, 0, 199);
    checkWord("w1c0f03", 21'h1C0F03);
    checkOutput("w1c0f03_overrun", {31'b0, overrun}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
